// File: rtl/stack_unit.sv
// Hardware LIFO stack of 8-bit entries with registered pop data and pointer/status outputs.
// Optional sticky overflow/underflow flags are built in when STACK_ERR_FLAGS_EN is defined.
module stack_unit #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTRW  = 5
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       StackWrite,
  input  logic       StackRead,
  input  logic [7:0] StackDatain,
  output logic [7:0] StackDataout,
  output logic       StackValid,
  output logic [7:0] StackAddress,
  output logic       StackFull,
  output logic       StackEmpty,
  output logic       StackOvf,
  output logic       StackUnf
);

  typedef enum logic [1:0] {StEmpty, StPartial, StFull} state_e;

  state_e            state_q, state_d;
  logic [PTRW-1:0]   sp_q, sp_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic [7:0]        mem_q [DEPTH];

  logic              wr_en;
  logic [PTRW-2:0]   wr_idx;
  logic [PTRW-1:0]   sp_p1, sp_m1;
  logic [PTRW-2:0]   top_idx;

  assign sp_p1   = sp_q + PTRW'(1);
  assign sp_m1   = sp_q - PTRW'(1);
  assign top_idx = sp_m1[PTRW-2:0];

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    data_d  = data_q;
    valid_d = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = sp_q[PTRW-2:0];
    if (StackWrite && StackRead && state_q != StEmpty) begin
      // Replace-top: old top goes out, new value takes its slot, SP unchanged.
      data_d  = mem_q[top_idx];
      wr_en   = 1'b1;
      wr_idx  = top_idx;
      valid_d = 1'b1;
    end else if (StackWrite && state_q != StFull) begin
      // Also covers push+pop while empty: the pop half is simply dropped.
      wr_en   = 1'b1;
      sp_d    = sp_p1;
      state_d = (sp_p1 == PTRW'(DEPTH)) ? StFull : StPartial;
    end else if (StackRead && !StackWrite && state_q != StEmpty) begin
      data_d  = mem_q[top_idx];
      sp_d    = sp_m1;
      valid_d = 1'b1;
      state_d = (sp_m1 == '0) ? StEmpty : StPartial;
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StEmpty;
      sp_q    <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Storage is deliberately not reset; SP guards against reading stale entries.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= StackDatain;
    end
  end

`ifdef STACK_ERR_FLAGS_EN
  logic ovf_q, unf_q;
  logic ovf_set, unf_set;

  assign ovf_set = StackWrite && !StackRead && state_q == StFull;
  assign unf_set = StackRead && state_q == StEmpty;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | ovf_set;
      unf_q <= unf_q | unf_set;
    end
  end

  assign StackOvf = ovf_q;
  assign StackUnf = unf_q;
`else
  assign StackOvf = 1'b0;
  assign StackUnf = 1'b0;
`endif

  assign StackDataout = data_q;
  assign StackValid   = valid_q;
  assign StackAddress = 8'(sp_q);
  assign StackEmpty   = (state_q == StEmpty);
  assign StackFull    = (state_q == StFull);

endmodule

// File: tb/tb_stack_unit.sv
// Directed self-checking bench for stack_unit at DEPTH=16; flag expectations
// follow whether STACK_ERR_FLAGS_EN is defined for the build.
module tb_stack_unit;

`ifdef STACK_ERR_FLAGS_EN
  localparam logic FlagsEn = 1'b1;
`else
  localparam logic FlagsEn = 1'b0;
`endif

  logic       clk;
  logic       Reset;
  logic       StackWrite;
  logic       StackRead;
  logic [7:0] StackDatain;
  logic [7:0] StackDataout;
  logic       StackValid;
  logic [7:0] StackAddress;
  logic       StackFull;
  logic       StackEmpty;
  logic       StackOvf;
  logic       StackUnf;

  int checks;
  int errors;

  stack_unit #(
    .DEPTH(16),
    .PTRW (5)
  ) dut (
    .clk         (clk),
    .Reset       (Reset),
    .StackWrite  (StackWrite),
    .StackRead   (StackRead),
    .StackDatain (StackDatain),
    .StackDataout(StackDataout),
    .StackValid  (StackValid),
    .StackAddress(StackAddress),
    .StackFull   (StackFull),
    .StackEmpty  (StackEmpty),
    .StackOvf    (StackOvf),
    .StackUnf    (StackUnf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus; outputs are stable 1 time unit after the edge.
  task automatic op(input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    StackWrite  = w;
    StackRead   = r;
    StackDatain = d;
    @(posedge clk);
    #1;
    StackWrite = 1'b0;
    StackRead  = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    StackWrite = 1'b0;
    StackRead  = 1'b0;
    Reset      = 1'b0;
    @(negedge clk);
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (StackAddress !== 8'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", StackAddress); end
    checks++; if (StackEmpty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", StackEmpty); end
    checks++; if (StackFull !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", StackFull); end
    checks++; if (StackDataout !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", StackDataout); end
    checks++; if (StackValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", StackValid); end
    checks++; if ({StackOvf, StackUnf} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {StackOvf, StackUnf}); end
  endtask

  task automatic test_lifo();
    logic [7:0] exp_pop [3];
    exp_pop[0] = 8'hC3; exp_pop[1] = 8'hB2; exp_pop[2] = 8'hA1;
    apply_reset();
    op(1'b1, 1'b0, 8'hA1);
    op(1'b1, 1'b0, 8'hB2);
    op(1'b1, 1'b0, 8'hC3);
    checks++; if (StackAddress !== 8'h03) begin errors++; $display("FAIL lifo_addr got %h exp 03", StackAddress); end
    checks++; if (StackEmpty !== 1'b0) begin errors++; $display("FAIL lifo_notempty got %b exp 0", StackEmpty); end
    for (int i = 0; i < 3; i++) begin
      op(1'b0, 1'b1, 8'h00);
      checks++; if (StackDataout !== exp_pop[i]) begin errors++; $display("FAIL lifo_pop%0d got %h exp %h", i, StackDataout, exp_pop[i]); end
      checks++; if (StackValid !== 1'b1) begin errors++; $display("FAIL lifo_valid%0d got %b exp 1", i, StackValid); end
    end
    checks++; if (StackEmpty !== 1'b1) begin errors++; $display("FAIL lifo_empty got %b exp 1", StackEmpty); end
    op(1'b0, 1'b0, 8'h00);
    checks++; if (StackValid !== 1'b0) begin errors++; $display("FAIL lifo_valid_pulse got %b exp 0", StackValid); end
    checks++; if (StackDataout !== 8'hA1) begin errors++; $display("FAIL lifo_hold got %h exp A1", StackDataout); end
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      op(1'b1, 1'b0, 8'(i));
      if (i == 14) begin
        checks++; if (StackFull !== 1'b0) begin errors++; $display("FAIL full_early got %b exp 0", StackFull); end
      end
    end
    checks++; if (StackFull !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", StackFull); end
    checks++; if (StackAddress !== 8'h10) begin errors++; $display("FAIL full_addr got %h exp 10", StackAddress); end
    op(1'b1, 1'b0, 8'hFF);
    checks++; if (StackAddress !== 8'h10) begin errors++; $display("FAIL ovf_addr got %h exp 10", StackAddress); end
    checks++; if (StackOvf !== FlagsEn) begin errors++; $display("FAIL ovf_flag got %b exp %b", StackOvf, FlagsEn); end
    op(1'b0, 1'b1, 8'h00);
    checks++; if (StackDataout !== 8'h0F) begin errors++; $display("FAIL ovf_pop got %h exp 0F", StackDataout); end
    checks++; if (StackAddress !== 8'h0F || StackFull !== 1'b0) begin errors++; $display("FAIL ovf_after got addr %h full %b exp 0F 0", StackAddress, StackFull); end
    checks++; if (StackOvf !== FlagsEn) begin errors++; $display("FAIL ovf_sticky got %b exp %b", StackOvf, FlagsEn); end
    // Replace-top while full: stays full, no overflow.
    apply_reset();
    for (int i = 0; i < 16; i++) op(1'b1, 1'b0, 8'(8'h20 + i));
    op(1'b1, 1'b1, 8'h99);
    checks++; if (StackDataout !== 8'h2F || StackValid !== 1'b1) begin errors++; $display("FAIL full_replace got %h/%b exp 2F/1", StackDataout, StackValid); end
    checks++; if (StackFull !== 1'b1 || StackOvf !== 1'b0) begin errors++; $display("FAIL full_replace_flags got full %b ovf %b exp 1 0", StackFull, StackOvf); end
    op(1'b0, 1'b1, 8'h00);
    checks++; if (StackDataout !== 8'h99) begin errors++; $display("FAIL full_replace_pop got %h exp 99", StackDataout); end
  endtask

  task automatic test_underflow();
    apply_reset();
    op(1'b0, 1'b1, 8'h00);
    checks++; if (StackValid !== 1'b0) begin errors++; $display("FAIL unf_valid got %b exp 0", StackValid); end
    checks++; if (StackDataout !== 8'h00) begin errors++; $display("FAIL unf_data got %h exp 00", StackDataout); end
    checks++; if (StackUnf !== FlagsEn) begin errors++; $display("FAIL unf_flag got %b exp %b", StackUnf, FlagsEn); end
    checks++; if (StackAddress !== 8'h00 || StackEmpty !== 1'b1) begin errors++; $display("FAIL unf_addr got %h/%b exp 00/1", StackAddress, StackEmpty); end
    op(1'b1, 1'b0, 8'h42);
    checks++; if (StackUnf !== FlagsEn) begin errors++; $display("FAIL unf_sticky got %b exp %b", StackUnf, FlagsEn); end
  endtask

  task automatic test_replace();
    apply_reset();
    op(1'b1, 1'b0, 8'h11);
    op(1'b1, 1'b0, 8'h55);
    op(1'b1, 1'b1, 8'h77);
    checks++; if (StackDataout !== 8'h55) begin errors++; $display("FAIL repl_data got %h exp 55", StackDataout); end
    checks++; if (StackValid !== 1'b1) begin errors++; $display("FAIL repl_valid got %b exp 1", StackValid); end
    checks++; if (StackAddress !== 8'h02) begin errors++; $display("FAIL repl_addr got %h exp 02", StackAddress); end
    checks++; if ({StackOvf, StackUnf} !== 2'b00) begin errors++; $display("FAIL repl_flags got %b exp 00", {StackOvf, StackUnf}); end
    op(1'b0, 1'b1, 8'h00);
    checks++; if (StackDataout !== 8'h77) begin errors++; $display("FAIL repl_pop1 got %h exp 77", StackDataout); end
    op(1'b0, 1'b1, 8'h00);
    checks++; if (StackDataout !== 8'h11) begin errors++; $display("FAIL repl_pop2 got %h exp 11", StackDataout); end
  endtask

  task automatic test_empty_pushpop();
    apply_reset();
    op(1'b1, 1'b1, 8'h3C);
    checks++; if (StackAddress !== 8'h01) begin errors++; $display("FAIL epp_addr got %h exp 01", StackAddress); end
    checks++; if (StackUnf !== FlagsEn) begin errors++; $display("FAIL epp_unf got %b exp %b", StackUnf, FlagsEn); end
    checks++; if (StackValid !== 1'b0 || StackDataout !== 8'h00) begin errors++; $display("FAIL epp_out got %b/%h exp 0/00", StackValid, StackDataout); end
    op(1'b0, 1'b1, 8'h00);
    checks++; if (StackDataout !== 8'h3C || StackValid !== 1'b1) begin errors++; $display("FAIL epp_pop got %h/%b exp 3C/1", StackDataout, StackValid); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 6; i++) op(1'b1, 1'b0, 8'(8'h80 + i));
    op(1'b0, 1'b1, 8'h00);
    checks++; if (StackAddress !== 8'h05 || StackValid !== 1'b1) begin errors++; $display("FAIL ar_pre got %h/%b exp 05/1", StackAddress, StackValid); end
    #2 Reset = 1'b0;
    #1;
    checks++; if (StackAddress !== 8'h00 || StackEmpty !== 1'b1 || StackFull !== 1'b0) begin errors++; $display("FAIL ar_ptr got %h/%b/%b exp 00/1/0", StackAddress, StackEmpty, StackFull); end
    checks++; if (StackDataout !== 8'h00 || StackValid !== 1'b0) begin errors++; $display("FAIL ar_data got %h/%b exp 00/0", StackDataout, StackValid); end
    // A push held across an edge during reset must be discarded.
    StackWrite  = 1'b1;
    StackDatain = 8'hEE;
    @(posedge clk);
    @(negedge clk);
    StackWrite = 1'b0;
    Reset      = 1'b1;
    op(1'b0, 1'b1, 8'h00);
    checks++; if (StackValid !== 1'b0 || StackAddress !== 8'h00 || StackDataout !== 8'h00) begin errors++; $display("FAIL ar_abort got %b/%h/%h exp 0/00/00", StackValid, StackAddress, StackDataout); end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    Reset       = 1'b1;
    StackWrite  = 1'b0;
    StackRead   = 1'b0;
    StackDatain = 8'h00;
    #2 Reset = 1'b0;
    test_reset();
    test_lifo();
    test_full();
    test_underflow();
    test_replace();
    test_empty_pushpop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
